// File: rtl/bos_pkg.sv
// Shared constants and state type for the UART transmit frame arbiter.
package bos_pkg;
  localparam int         N_SRC     = 19;
  localparam int         SRC_W     = 5;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    ADDR,
    LEN,
    DATA,
    CSUM
  } tx_arb_state_t;
endpackage

// File: rtl/tx_frame_arbiter_if.sv
// Source-bus and UART-stream signals of the transmit frame arbiter.
interface tx_frame_arbiter_if #(
  parameter int N_SRC = bos_pkg::N_SRC
);
  logic [N_SRC-1:0]           have_msg_bus;
  logic [8*N_SRC-1:0]         data_bus;
  logic [8*N_SRC-1:0]         len_bus;
  logic [N_SRC-1:0]           rdreq_bus;
  logic [7:0]                 tx_data;
  logic                       tx_valid;
  logic                       tx_ready;
  logic                       busy;
  logic [bos_pkg::SRC_W-1:0]  cur_src;

  // A byte moves when tx_valid && tx_ready at a rising edge; while valid is
  // high and ready low, tx_data holds and valid cannot drop.
  modport master (
    input  have_msg_bus, data_bus, len_bus, tx_ready,
    output rdreq_bus, tx_data, tx_valid, busy, cur_src
  );

  modport slave (
    output have_msg_bus, data_bus, len_bus, tx_ready,
    input  rdreq_bus, tx_data, tx_valid, busy, cur_src
  );
endinterface

// File: rtl/tx_frame_arbiter_rr_arbiter.sv
// Combinational rotate-priority search: first set request at or after ptr.
module rr_arbiter #(
  parameter int N  = 19,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] grant_idx,
  output logic          grant_valid
);
  int            j;
  logic [PW-1:0] idx;

  // Scanning from the far end lets the closest hit overwrite the others.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    j           = 0;
    idx         = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      idx = j[PW-1:0];
      if (req[idx]) begin
        grant_idx   = idx;
        grant_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/tx_frame_arbiter.sv
// Round-robin framer: drains one source's message as SYNC, ADDR, LEN, payload, XOR.
module tx_frame_arbiter
  import bos_pkg::*;
#(
  parameter int         N_SRC     = bos_pkg::N_SRC,
  parameter logic [7:0] SYNC_BYTE = bos_pkg::SYNC_BYTE
) (
  input  logic              clk,
  input  logic              rst,
  tx_frame_arbiter_if.master bus,
  output tx_arb_state_t     dbg_state
);
  localparam int             SW       = SRC_W;
  localparam logic [SW-1:0]  LAST_SRC = SW'(N_SRC - 1);

  tx_arb_state_t state;
  logic [SW-1:0] cur_src_q, rr_ptr, grant_idx;
  logic          grant_valid, tx_valid_q, busy_q, hs;
  logic [7:0]    len_q, rem_q, csum, grant_len, head, tx_byte;

  rr_arbiter #(.N(N_SRC), .PW(SW)) u_rr (
    .req         (bus.have_msg_bus),
    .ptr         (rr_ptr),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_comb begin
    grant_len = '0;
    head      = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_idx == SW'(i)) grant_len = bus.len_bus[8*i +: 8];
      if (cur_src_q == SW'(i)) head = bus.data_bus[8*i +: 8];
    end
  end

  // Payload comes straight from the show-ahead head so a popped FIFO's new
  // head is what goes out on the following DATA cycle.
  always_comb begin
    tx_byte = '0;
    case (state)
      SYNC:    tx_byte = SYNC_BYTE;
      ADDR:    tx_byte = {3'b000, cur_src_q};
      LEN:     tx_byte = len_q;
      DATA:    tx_byte = head;
      CSUM:    tx_byte = csum;
      default: tx_byte = '0;
    endcase
  end

  assign hs = tx_valid_q && bus.tx_ready;

  always_comb begin
    bus.rdreq_bus = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (state == DATA && hs && !rst && cur_src_q == SW'(i)) bus.rdreq_bus[i] = 1'b1;
    end
  end

  assign bus.tx_data  = tx_byte;
  assign bus.tx_valid = tx_valid_q;
  assign bus.busy     = busy_q;
  assign bus.cur_src  = cur_src_q;
  assign dbg_state    = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_src_q  <= '0;
      rr_ptr     <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      csum       <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant_valid) begin
          cur_src_q  <= grant_idx;
          len_q      <= grant_len;
          rem_q      <= grant_len;
          csum       <= '0;
          tx_valid_q <= 1'b1;
          busy_q     <= 1'b1;
          state      <= SYNC;
        end
        SYNC: if (hs) state <= ADDR;
        ADDR: if (hs) begin
          csum  <= csum ^ tx_byte;
          state <= LEN;
        end
        LEN: if (hs) begin
          csum  <= csum ^ tx_byte;
          state <= (len_q != 8'd0) ? DATA : CSUM;
        end
        DATA: if (hs) begin
          csum  <= csum ^ tx_byte;
          rem_q <= rem_q - 8'd1;
          if (rem_q == 8'd1) state <= CSUM;
        end
        CSUM: if (hs) begin
          rr_ptr     <= (cur_src_q == LAST_SRC) ? '0 : cur_src_q + SW'(1);
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter with per-source show-ahead FIFO models.
module tb_tx_frame_arbiter;
  import bos_pkg::*;
  localparam int N = 19;

  logic          clk = 1'b0;
  logic          rst;
  tx_arb_state_t dbg_state;
  tx_frame_arbiter_if #(.N_SRC(N)) bus ();

  tx_frame_arbiter #(.N_SRC(N), .SYNC_BYTE(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- source FIFO models and monitor ----------------
  logic [7:0] mem [N][1024];
  int         rd_ptr [N];
  int         wr_ptr [N];
  int         pops [N];
  logic [7:0] cap_q[$];
  int         cap_cyc[$];
  logic [7:0] exp_q[$];
  int         cyc, stall_err, bad_rdreq;
  logic       stall_pend;
  logic [7:0] stall_data;
  int         n_checks, n_fail;

  initial begin
    for (int i = 0; i < N; i++) begin
      rd_ptr[i] = 0;
      wr_ptr[i] = 0;
      pops[i]   = 0;
      for (int k = 0; k < 1024; k++) mem[i][k] = 8'h00;
    end
  end

  always_comb begin
    bus.data_bus = '0;
    for (int i = 0; i < N; i++) bus.data_bus[8*i +: 8] = mem[i][rd_ptr[i]];
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      if (bus.rdreq_bus != '0) bad_rdreq = bad_rdreq + 1;
      stall_pend = 1'b0;
    end else begin
      if (bus.tx_valid && bus.tx_ready) begin
        cap_q.push_back(bus.tx_data);
        cap_cyc.push_back(cyc);
      end
      if (stall_pend && bus.tx_data !== stall_data) stall_err = stall_err + 1;
      stall_pend = bus.tx_valid && !bus.tx_ready;
      stall_data = bus.tx_data;
      for (int i = 0; i < N; i++) begin
        if (bus.rdreq_bus[i]) begin
          pops[i]   = pops[i] + 1;
          rd_ptr[i] <= rd_ptr[i] + 1;
          if (!(dbg_state == DATA && bus.tx_valid && bus.tx_ready && bus.cur_src == 5'(i)))
            bad_rdreq = bad_rdreq + 1;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_msg(input int src, input int len, input int base, input int step,
                          input bit add_exp);
    logic [7:0] cs, b;
    cs = src[7:0] ^ len[7:0];
    if (add_exp) begin
      exp_q.push_back(8'hA5);
      exp_q.push_back(src[7:0]);
      exp_q.push_back(len[7:0]);
    end
    for (int k = 0; k < len; k++) begin
      b = 8'(base + k * step);
      mem[src][wr_ptr[src] + k] = b;
      cs = cs ^ b;
      if (add_exp) exp_q.push_back(b);
    end
    if (add_exp) exp_q.push_back(cs);
    wr_ptr[src] = wr_ptr[src] + len;
    bus.len_bus[8*src +: 8] = len[7:0];
  endtask

  task automatic wait_busy(input string tag);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.busy) break;
    end
    check(tag, 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget, input bit rnd);
    for (int c = 0; c < budget; c++) begin
      if (cap_q.size() >= n) break;
      @(negedge clk);
      if (rnd) bus.tx_ready = 1'($urandom_range(0, 1));
    end
    bus.tx_ready = 1'b1;
    check(tag, 32'(cap_q.size() >= n), 32'd1);
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_count"}, cap_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++)
      check(tag, {24'd0, cap_q[k]}, {24'd0, exp_q[k]});
    cap_q.delete();
    cap_cyc.delete();
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int p0;
    n_checks = 0; n_fail = 0; cyc = 0; stall_err = 0; bad_rdreq = 0; stall_pend = 1'b0;
    rst = 1'b1;
    bus.tx_ready = 1'b1;
    bus.have_msg_bus = '0;
    bus.len_bus = '0;
    repeat (3) @(negedge clk);

    check("rst_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_data", 32'(bus.tx_data), 32'd0);
    check("rst_rdreq", 32'(bus.rdreq_bus), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_cur_src", 32'(bus.cur_src), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk);
    cap_q.delete(); cap_cyc.delete();

    // Round-robin: 1, 5, 18 pending; 1 comes back during frame 5.
    push_msg(1, 1, 8'h11, 0, 1);
    push_msg(5, 2, 8'h51, 1, 1);
    push_msg(18, 3, 8'hE1, 1, 1);
    bus.have_msg_bus[1] = 1'b1;
    bus.have_msg_bus[5] = 1'b1;
    bus.have_msg_bus[18] = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (cap_q.size() >= 5 && cap_q.size() < 7) bus.have_msg_bus[1] = 1'b0;
      if (cap_q.size() >= 7 && exp_q.size() == 18) begin
        push_msg(1, 2, 8'h1A, 1, 1);
        bus.have_msg_bus[1] = 1'b1;
      end
      if (cap_q.size() >= 11) bus.have_msg_bus[5] = 1'b0;
      if (cap_q.size() >= 18) bus.have_msg_bus[18] = 1'b0;
      if (cap_q.size() >= 24) break;
    end
    bus.have_msg_bus = '0;
    check("rr_done", 32'(cap_q.size()), 32'd24);
    if (cap_q.size() >= 24) begin
      check("rr_first", 32'(cap_q[1]), 32'd1);
      check("rr_second", 32'(cap_q[6]), 32'd5);
      check("rr_third", 32'(cap_q[12]), 32'd18);
      check("rr_fourth", 32'(cap_q[19]), 32'd1);
      check("rr_spacing", 32'(cap_cyc[5] - cap_cyc[4]), 32'd2);
    end
    compare_all("rr_bytes");

    // Single message, no backpressure; bus changes after grant are ignored.
    p0 = pops[8];
    push_msg(8, 2, 8'h12, 8'h22, 1);
    bus.have_msg_bus[8] = 1'b1;
    wait_busy("t1_grant");
    bus.have_msg_bus[8] = 1'b0;
    bus.len_bus[8*8 +: 8] = 8'h77;
    wait_bytes("t1_done", 6, 50, 0);
    if (cap_q.size() >= 6) begin
      check("t1_csum", 32'(cap_q[5]), 32'h2C);
      check("t1_span", 32'(cap_cyc[5] - cap_cyc[0]), 32'd5);
    end
    check("t1_pops", 32'(pops[8] - p0), 32'd2);
    compare_all("t1_bytes");

    // Zero length.
    p0 = pops[3];
    push_msg(3, 0, 0, 0, 1);
    bus.have_msg_bus[3] = 1'b1;
    wait_busy("t2_grant");
    bus.have_msg_bus[3] = 1'b0;
    wait_bytes("t2_done", 4, 50, 0);
    if (cap_q.size() >= 4) check("t2_csum", 32'(cap_q[3]), 32'h03);
    check("t2_pops", 32'(pops[3] - p0), 32'd0);
    compare_all("t2_bytes");

    // Backpressure over a len=4 frame.
    p0 = pops[9];
    push_msg(9, 4, 8'h90, 3, 1);
    bus.have_msg_bus[9] = 1'b1;
    wait_busy("bp_grant");
    bus.have_msg_bus[9] = 1'b0;
    wait_bytes("bp_done", 8, 400, 1);
    check("bp_pops", 32'(pops[9] - p0), 32'd4);
    check("bp_stable", 32'(stall_err), 32'd0);
    compare_all("bp_bytes");

    // Max length on source 0, then source 18.
    p0 = pops[0];
    push_msg(0, 255, 8'h01, 7, 1);
    bus.have_msg_bus[0] = 1'b1;
    wait_busy("max_grant");
    bus.have_msg_bus[0] = 1'b0;
    push_msg(18, 1, 8'h5A, 0, 1);
    bus.have_msg_bus[18] = 1'b1;
    wait_bytes("max_done", 259, 600, 0);
    wait_busy("max_grant18");
    bus.have_msg_bus[18] = 1'b0;
    wait_bytes("max_done18", 264, 50, 0);
    check("max_pops", 32'(pops[0] - p0), 32'd255);
    if (cap_q.size() >= 264) begin
      check("max_len_byte", 32'(cap_q[2]), 32'd255);
      check("max_next_src", 32'(cap_q[260]), 32'd18);
    end
    compare_all("max_bytes");

    // Pointer wrapped to 0: source 0 beats source 17.
    push_msg(0, 1, 8'h0F, 0, 1);
    push_msg(17, 1, 8'h71, 0, 1);
    bus.have_msg_bus[0] = 1'b1;
    bus.have_msg_bus[17] = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (cap_q.size() >= 5) bus.have_msg_bus[0] = 1'b0;
      if (cap_q.size() >= 10) break;
    end
    bus.have_msg_bus = '0;
    if (cap_q.size() >= 2) check("wrap_first", 32'(cap_q[1]), 32'd0);
    compare_all("wrap_bytes");

    // Reset after 3 of 10 payload bytes.
    p0 = pops[6];
    push_msg(6, 10, 8'h60, 1, 0);
    bus.have_msg_bus[6] = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (pops[6] - p0 >= 3) break;
    end
    check("mid_pops_before", 32'(pops[6] - p0), 32'd3);
    rst = 1'b1;
    bus.tx_ready = 1'b0;
    bus.have_msg_bus[6] = 1'b0;
    @(negedge clk);
    check("mid_valid", 32'(bus.tx_valid), 32'd0);
    check("mid_rdreq", 32'(bus.rdreq_bus), 32'd0);
    check("mid_busy", 32'(bus.busy), 32'd0);
    check("mid_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    bus.tx_ready = 1'b1;
    cap_q.delete(); cap_cyc.delete(); exp_q.delete();
    push_msg(2, 1, 8'h22, 0, 1);
    push_msg(7, 1, 8'h77, 0, 1);
    bus.have_msg_bus[2] = 1'b1;
    bus.have_msg_bus[7] = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (cap_q.size() >= 5) bus.have_msg_bus[2] = 1'b0;
      if (cap_q.size() >= 10) break;
    end
    bus.have_msg_bus = '0;
    if (cap_q.size() >= 2) begin
      check("post_sync", 32'(cap_q[0]), 32'hA5);
      check("post_src", 32'(cap_q[1]), 32'd2);
    end
    check("mid_pops_after", 32'(pops[6] - p0), 32'd3);
    compare_all("post_bytes");

    repeat (3) @(negedge clk);
    check("rdreq_legal", 32'(bad_rdreq), 32'd0);
    check("stall_stable", 32'(stall_err), 32'd0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
